trng_health_packer: RTL and testbench

- Downstream consumer of the 8-bit TRNG output stream.
- Runs continuous health tests on every sample: a repetition count test (RCT) and an adaptive proportion test (APT).
- Discards a startup block of samples, then packs accepted bytes into 32-bit words and buffers them in a small FIFO behind a valid/ready interface.
- Any health failure raises a sticky alarm and stops output until software clears it.

---
 rtl/trng_health_packer_if.sv | 20 ++
 rtl/trng_health_packer.sv | 207 ++++++++++++++++++++
 tb/tb_trng_health_packer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trng_health_packer_if.sv
// Output word stream of the TRNG health packer: a FIFO head with valid/ready.
// The master side drives the word and its valid flag; the slave side
// returns ready.
interface trng_health_packer_if;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/trng_health_packer.sv
// TRNG health packer: runs the repetition count test and the adaptive
// proportion test on every accepted 8-bit sample, throws away a startup
// block, packs the remaining bytes little-endian into 32-bit words and queues
// them in a small FIFO. Any health failure latches a sticky alarm. The alarm
// stops all output until software clears it.
module trng_health_packer #(
    parameter int RCT_CUTOFF      = 21,
    parameter int APT_WINDOW      = 512,
    parameter int APT_CUTOFF      = 13,
    parameter int STARTUP_SAMPLES = 1024,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    input  logic                 clear_alarm,
    trng_health_packer_if.master out_if,
    output logic                 health_ok,
    output logic                 alarm,
    output logic                 rct_fail,
    output logic                 apt_fail,
    output logic                 overflow
);
    localparam int REP_W  = $clog2(RCT_CUTOFF + 1);
    localparam int IDX_W  = $clog2(APT_WINDOW);
    localparam int CNT_W  = $clog2(APT_CUTOFF + 1);
    localparam int SU_W   = $clog2(STARTUP_SAMPLES + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_STARTUP,
        ST_RUN,
        ST_ALARM
    } state_t;

    state_t state, state_next;

    logic [7:0]        rct_last;
    logic [REP_W-1:0]  rct_rep, rct_rep_next;
    logic [IDX_W-1:0]  apt_idx;
    logic [7:0]        apt_ref;
    logic [CNT_W-1:0]  apt_cnt, apt_cnt_next;
    logic [SU_W-1:0]   startup_cnt;
    logic [1:0]        byte_idx;
    logic [23:0]       word_buf;
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [FCNT_W-1:0] fifo_count;

    logic        accept, rct_hit, apt_hit, fail, startup_done;
    logic        push, push_ok, pop, fifo_full, out_valid_int;
    logic [31:0] push_word;

    // Health-test evaluation of the current sample plus the FIFO push/pop decision.
    always_comb begin
        accept       = in_valid && (state != ST_ALARM);
        rct_rep_next = REP_W'(1);
        if ((rct_rep != '0) && (in_data == rct_last)) begin
            rct_rep_next = (rct_rep == REP_W'(RCT_CUTOFF)) ? rct_rep : rct_rep + REP_W'(1);
        end
        rct_hit      = accept && (rct_rep_next == REP_W'(RCT_CUTOFF));
        apt_cnt_next = apt_cnt;
        apt_hit      = 1'b0;
        if (apt_idx == '0) begin
            apt_cnt_next = CNT_W'(1);
        end else if (in_data == apt_ref) begin
            apt_cnt_next = apt_cnt + CNT_W'(1);
            apt_hit      = accept && (apt_cnt_next == CNT_W'(APT_CUTOFF));
        end
        fail         = rct_hit || apt_hit;
        startup_done = accept && (state == ST_STARTUP) && !fail &&
                       (startup_cnt == SU_W'(STARTUP_SAMPLES - 1));
        push         = accept && (state == ST_RUN) && !fail && (byte_idx == 2'd3);
        push_word    = {in_data, word_buf};
        fifo_full    = (fifo_count == FCNT_W'(FIFO_DEPTH));
        pop          = out_valid_int && out_if.out_ready;
        push_ok      = push && (!fifo_full || pop);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_STARTUP;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a failure always wins over finishing the startup block.
    always_comb begin
        state_next = state;
        case (state)
            ST_STARTUP: begin
                if (fail) begin
                    state_next = ST_ALARM;
                end else if (startup_done) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fail) begin
                    state_next = ST_ALARM;
                end
            end
            ST_ALARM: begin
                if (clear_alarm) begin
                    state_next = ST_STARTUP;
                end
            end
            default: state_next = ST_STARTUP;
        endcase
    end

    // Health-test state and sticky cause flags; frozen in ALARM, wiped by a clear.
    always_ff @(posedge clk) begin
        if (!reset_n || ((state == ST_ALARM) && clear_alarm)) begin
            rct_last    <= '0;
            rct_rep     <= '0;
            apt_idx     <= '0;
            apt_ref     <= '0;
            apt_cnt     <= '0;
            startup_cnt <= '0;
            rct_fail    <= 1'b0;
            apt_fail    <= 1'b0;
        end else if (accept) begin
            rct_last <= in_data;
            rct_rep  <= rct_rep_next;
            if (apt_idx == '0) begin
                apt_ref <= in_data;
            end
            apt_cnt <= apt_cnt_next;
            apt_idx <= apt_idx + IDX_W'(1);
            if (state == ST_STARTUP) begin
                startup_cnt <= startup_cnt + SU_W'(1);
            end
            if (rct_hit) begin
                rct_fail <= 1'b1;
            end
            if (apt_hit) begin
                apt_fail <= 1'b1;
            end
        end
    end

    // Byte packer; the fourth byte bypasses the buffer straight into the FIFO.
    always_ff @(posedge clk) begin
        if (!reset_n || (state == ST_ALARM)) begin
            byte_idx <= '0;
            word_buf <= '0;
        end else if (accept && (state == ST_RUN) && !fail) begin
            case (byte_idx)
                2'd0:    word_buf[7:0]   <= in_data;
                2'd1:    word_buf[15:8]  <= in_data;
                2'd2:    word_buf[23:16] <= in_data;
                default: ;
            endcase
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // FIFO storage; a push into a full FIFO is allowed only when the head leaves this cycle.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag; ALARM flushes the queue.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else if (state == ST_ALARM) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            if (clear_alarm) begin
                overflow <= 1'b0;
            end
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: ;
            endcase
        end
    end

    assign out_valid_int    = (state == ST_RUN) && (fifo_count != '0);
    assign out_if.out_valid = out_valid_int;
    assign out_if.out_data  = (fifo_count != '0) ? fifo_mem[rd_ptr] : 32'h0;
    assign health_ok        = (state == ST_RUN);
    assign alarm            = (state == ST_ALARM);
endmodule

// File: tb/tb_trng_health_packer.sv
// Self-checking bench for trng_health_packer: a table of startup/packing
// vectors, hand-written corner-case sequences, then randomized traffic checked
// every cycle against a queue-based reference model.
module tb_trng_health_packer;
    localparam int RCT_CUTOFF      = 4;
    localparam int APT_WINDOW      = 16;
    localparam int APT_CUTOFF      = 5;
    localparam int STARTUP_SAMPLES = 8;
    localparam int FIFO_DEPTH      = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       clear_alarm = 1'b0;
    logic       health_ok, alarm, rct_fail, apt_fail, overflow;

    trng_health_packer_if out_if ();

    trng_health_packer #(
        .RCT_CUTOFF      (RCT_CUTOFF),
        .APT_WINDOW      (APT_WINDOW),
        .APT_CUTOFF      (APT_CUTOFF),
        .STARTUP_SAMPLES (STARTUP_SAMPLES),
        .FIFO_DEPTH      (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .clear_alarm (clear_alarm),
        .out_if      (out_if),
        .health_ok   (health_ok),
        .alarm       (alarm),
        .rct_fail    (rct_fail),
        .apt_fail    (apt_fail),
        .overflow    (overflow)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int assertions = 0;
    int failures   = 0;

    // Reference model: the accepted-sample history, the current APT window,
    // pending bytes and queued words, all kept as plain queues.
    typedef enum {M_STARTUP, M_RUN, M_ALARM} mstate_t;
    mstate_t     m_state;
    bit          m_rct, m_apt, m_ovf;
    int          m_su;
    bit [7:0]    hist_q[$];
    bit [7:0]    win_q[$];
    bit [7:0]    byte_q[$];
    bit [31:0]   word_q[$];

    typedef struct {
        bit        v;
        bit [7:0]  data;
        bit        rdy;
        bit        exp_valid;
        bit        exp_health;
        bit [31:0] exp_data;
    } vec_t;
    vec_t vecs[17];

    bit       r_rst, r_v, r_clr, r_rdy;
    bit [7:0] r_d;
    int       mode;

    function automatic void model_reset();
        m_state = M_STARTUP;
        m_rct = 1'b0;
        m_apt = 1'b0;
        m_ovf = 1'b0;
        m_su = 0;
        hist_q.delete();
        win_q.delete();
        byte_q.delete();
        word_q.delete();
    endfunction

    task automatic model_edge(bit rst, bit v, bit [7:0] d, bit clr, bit rdy);
        bit        pop;
        bit        rct_hit, apt_hit;
        int        run, cnt;
        bit [31:0] w;
        if (!rst) begin
            model_reset();
            return;
        end
        if (m_state == M_ALARM) begin
            word_q.delete();
            byte_q.delete();
            if (clr) model_reset();
            return;
        end
        pop = (m_state == M_RUN) && (word_q.size() > 0) && rdy;
        if (pop) void'(word_q.pop_front());
        if (!v) return;
        hist_q.push_back(d);
        if (hist_q.size() > RCT_CUTOFF) void'(hist_q.pop_front());
        run = 0;
        for (int i = hist_q.size() - 1; i >= 0; i--) begin
            if (hist_q[i] != d) break;
            run++;
        end
        rct_hit = (run == RCT_CUTOFF);
        if (win_q.size() == APT_WINDOW) win_q.delete();
        win_q.push_back(d);
        cnt = 0;
        foreach (win_q[i]) if (win_q[i] == win_q[0]) cnt++;
        apt_hit = (win_q.size() > 1) && (d == win_q[0]) && (cnt == APT_CUTOFF);
        if (rct_hit || apt_hit) begin
            m_state = M_ALARM;
            m_rct = m_rct | rct_hit;
            m_apt = m_apt | apt_hit;
            return;
        end
        if (m_state == M_STARTUP) begin
            m_su++;
            if (m_su == STARTUP_SAMPLES) m_state = M_RUN;
            return;
        end
        byte_q.push_back(d);
        if (byte_q.size() == 4) begin
            w = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
            byte_q.delete();
            if (word_q.size() < FIFO_DEPTH) word_q.push_back(w);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compare_model();
        bit       exp_valid;
        bit [5:0] exp_flags;
        exp_valid = (m_state == M_RUN) && (word_q.size() > 0);
        exp_flags = {exp_valid, m_state == M_RUN, m_state == M_ALARM, m_rct, m_apt, m_ovf};
        check_output("model flags {valid,ok,alarm,rct,apt,ovf}",
                     {26'b0, out_if.out_valid, health_ok, alarm, rct_fail, apt_fail, overflow},
                     {26'b0, exp_flags});
        if (exp_valid) check_output("model out_data", out_if.out_data, word_q[0]);
    endtask

    task automatic apply_stimulus(bit rst, bit v, bit [7:0] d, bit clr, bit rdy);
        reset_n          = rst;
        in_valid         = v;
        in_data          = d;
        clear_alarm      = clr;
        out_if.out_ready = rdy;
        model_edge(rst, v, d, clr, rdy);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic feed(bit [7:0] d, bit rdy);
        apply_stimulus(1'b1, 1'b1, d, 1'b0, rdy);
    endtask

    task automatic idle(bit rdy);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, rdy);
    endtask

    function automatic void fill_vectors();
        vecs[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 8'h06, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 8'h08, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[9]  = '{1'b1, 8'h09, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 8'h0A, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 8'h0B, 1'b1, 1'b1, 1'b1, 32'h0B0A0908};
        vecs[12] = '{1'b1, 8'h0C, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[13] = '{1'b1, 8'h0D, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[14] = '{1'b1, 8'h0E, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[15] = '{1'b1, 8'h0F, 1'b1, 1'b1, 1'b1, 32'h0F0E0D0C};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0};
    endfunction

    // Directed table, corner-case sequences, then randomized traffic against the model.
    initial begin
        logic [31:0] drain_exp [4];
        drain_exp[0] = 32'h43424140;
        drain_exp[1] = 32'h47464544;
        drain_exp[2] = 32'h4B4A4948;
        drain_exp[3] = 32'h4F4E4D4C;
        fill_vectors();
        model_reset();

        // Reset state.
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_output("reset flags", {26'b0, out_if.out_valid, health_ok, alarm, rct_fail, apt_fail, overflow}, 32'h0);
        check_output("reset out_data", out_if.out_data, 32'h0);

        // Startup discard and the first two packed words.
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(1'b1, vecs[i].v, vecs[i].data, 1'b0, vecs[i].rdy);
            check_output($sformatf("vec%0d out_valid", i), out_if.out_valid, vecs[i].exp_valid);
            check_output($sformatf("vec%0d health_ok", i), health_ok, vecs[i].exp_health);
            if (vecs[i].exp_valid) check_output($sformatf("vec%0d out_data", i), out_if.out_data, vecs[i].exp_data);
        end

        // RCT: three repeats are fine, four repeats trip the alarm.
        for (int i = 0; i < 4; i++) feed(8'h10 + 8'(i), 1'b1);
        for (int i = 0; i < 3; i++) feed(8'h5A, 1'b1);
        feed(8'hA5, 1'b1);
        check_output("rct below cutoff alarm", alarm, 1'b0);
        for (int i = 0; i < 4; i++) feed(8'h5A, 1'b1);
        check_output("rct alarm", alarm, 1'b1);
        check_output("rct rct_fail", rct_fail, 1'b1);
        check_output("rct apt_fail", apt_fail, 1'b0);
        check_output("rct out_valid", out_if.out_valid, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Clear: sample in the clear cycle ignored, fresh startup, fresh byte 0.
        apply_stimulus(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
        check_output("clear alarm", alarm, 1'b0);
        check_output("clear rct_fail", rct_fail, 1'b0);
        for (int i = 0; i < 8; i++) begin
            feed(8'h20 + 8'(i), 1'b0);
            if (i == 6) check_output("clear startup health 7th", health_ok, 1'b0);
        end
        check_output("clear startup health 8th", health_ok, 1'b1);
        for (int i = 0; i < 4; i++) feed(8'h28 + 8'(i), 1'b0);
        check_output("clear first word", out_if.out_data, 32'h2B2A2928);
        idle(1'b1);

        // Overflow: four words held, the fifth dropped, then in-order drain.
        for (int i = 0; i < 20; i++) feed(8'h40 + 8'(i), 1'b0);
        check_output("ovf overflow", overflow, 1'b1);
        check_output("ovf health", health_ok, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("drain word%0d", i), out_if.out_data, drain_exp[i]);
            idle(1'b1);
        end
        check_output("drain empty", out_if.out_valid, 1'b0);

        // APT: four hits in one window pass, five in the next window fail.
        for (int i = 0; i < 16; i++) feed(((i % 3 == 0) && (i <= 9)) ? 8'h33 : 8'h60 + 8'(i), 1'b1);
        check_output("apt window1 alarm", alarm, 1'b0);
        for (int i = 0; i < 9; i++) begin
            feed((i % 2 == 0) ? 8'h33 : 8'h70 + 8'(i), 1'b1);
            if (i == 7) check_output("apt idx7 alarm", alarm, 1'b0);
        end
        check_output("apt apt_fail", apt_fail, 1'b1);
        check_output("apt rct_fail", rct_fail, 1'b0);
        check_output("apt alarm", alarm, 1'b1);

        // Reset in RUN with two words queued and two bytes pending.
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) feed(8'h80 + 8'(i), 1'b0);
        for (int i = 0; i < 10; i++) feed(8'h90 + 8'(i), 1'b0);
        check_output("pre-reset valid", out_if.out_valid, 1'b1);
        apply_stimulus(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        check_output("mid reset flags", {26'b0, out_if.out_valid, health_ok, alarm, rct_fail, apt_fail, overflow}, 32'h0);
        check_output("mid reset out_data", out_if.out_data, 32'h0);
        for (int i = 0; i < 8; i++) begin
            feed(8'hB0 + 8'(i), 1'b0);
            if (i == 6) check_output("re-startup health 7th", health_ok, 1'b0);
        end
        check_output("re-startup health 8th", health_ok, 1'b1);
        for (int i = 0; i < 4; i++) feed(8'hB8 + 8'(i), 1'b0);
        check_output("re-startup first word", out_if.out_data, 32'hBBBAB9B8);

        // Randomized traffic: wide and narrow alphabets to exercise packing and failures.
        for (int c = 0; c < 4000; c++) begin
            mode  = (c / 400) % 3;
            r_rst = ($urandom_range(0, 599) != 0);
            r_v   = ($urandom_range(0, 3) != 0);
            r_clr = ($urandom_range(0, 15) == 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            if (mode == 0) r_d = 8'($urandom);
            else if (mode == 1) r_d = 8'($urandom_range(0, 3));
            else r_d = 8'($urandom_range(0, 15));
            apply_stimulus(r_rst, r_v, r_d, r_clr, r_rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
